// File: rtl/car_sim_pkg.sv
// ----------------------------------------------------------------------------
// car_sim_pkg
// Types and constants shared across the car simulation blocks.
//   state_t        : turn-signal controller FSM states
//   DEFAULT_CLK_HZ : default system clock frequency in Hz
// ----------------------------------------------------------------------------
package car_sim_pkg;

   localparam int DEFAULT_CLK_HZ = 50_000_000;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LEFT      = 3'd1,
      RIGHT     = 3'd2,
      HAZARD    = 3'd3,
      ESS       = 3'd4,
      COMFORT_L = 3'd5,
      COMFORT_R = 3'd6
   } state_t;

endpackage

// File: rtl/blink_timebase.sv
// ----------------------------------------------------------------------------
// blink_timebase
// Phase counter for the lamp flasher. Counts 0..P-1 (or 0..PE-1 when the
// ESS rate is selected) and wraps. The on_phase/phase_start outputs describe
// the count being loaded at the coming clock edge, so the caller can register
// its lamp outputs in the same edge and keep a one-cycle input-to-lamp latency.
//
// Build option: TURN_SIGNAL_COMFORT_EN adds the on_last output.
//
// Ports
//   clk         in  system clock
//   rst         in  synchronous active-high reset (counter to 0)
//   restart     in  load 0 at the coming edge instead of counting
//   sel_ess     in  1 = ESS period PE for the count being loaded, 0 = P
//   on_phase    out count being loaded lies in the first half of the period
//   phase_start out count being loaded is 0 (an on-phase begins)
//   on_last     out current count is the last on-phase cycle of a normal-rate
//                   period (only used by comfort states, which never run at
//                   the ESS rate)
// ----------------------------------------------------------------------------
module blink_timebase #(
   parameter int P  = 20,
   parameter int PE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic sel_ess,
   output logic on_phase,
   output logic phase_start
`ifdef TURN_SIGNAL_COMFORT_EN
   ,
   output logic on_last
`endif
);

   // PE <= P, so a counter sized for P also covers the ESS period.
   localparam int W = $clog2(P);
   localparam logic [W-1:0] P_LAST    = W'(P - 1);
   localparam logic [W-1:0] PE_LAST   = W'(PE - 1);
   localparam logic [W-1:0] P_HALF    = W'(P / 2);
   localparam logic [W-1:0] PE_HALF   = W'(PE / 2);

   logic [W-1:0] r_cnt;
   logic [W-1:0] w_cnt_nxt;
   logic [W-1:0] w_last;
   logic [W-1:0] w_half;

   always_comb begin
      w_last = sel_ess ? PE_LAST : P_LAST;
      w_half = sel_ess ? PE_HALF : P_HALF;
      // >= rather than == keeps the count in range even if the period shrinks.
      if (restart || (r_cnt >= w_last)) begin
         w_cnt_nxt = '0;
      end else begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   assign on_phase    = (w_cnt_nxt < w_half);
   assign phase_start = (w_cnt_nxt == '0);

`ifdef TURN_SIGNAL_COMFORT_EN
   assign on_last = (r_cnt == (P_HALF - 1'b1));
`endif

endmodule

// File: rtl/turn_signal_ctrl.sv
// ----------------------------------------------------------------------------
// turn_signal_ctrl
// Turn-signal / hazard / emergency-stop-signal lamp controller. Priority each
// cycle: ess_active > sw_hazard > single stalk > comfort > IDLE. Both stalks
// high at once counts as no stalk. Lamps and click are registered: an input
// change shows on the lamps one cycle later. Any state change restarts the
// phase so the first on-phase is full length (except LEFT->COMFORT_L and
// RIGHT->COMFORT_R, which continue the running phase).
//
// Build option: TURN_SIGNAL_COMFORT_EN enables the comfort (tap-to-flash)
// states and the flash counter. Without it a stalk release goes to IDLE.
//
// Ports
//   clk        in  system clock
//   rst        in  synchronous active-high reset
//   sw_left    in  left stalk level (already synchronised)
//   sw_right   in  right stalk level
//   sw_hazard  in  hazard switch level
//   ess_active in  emergency-stop-signal request
//   led_left   out left lamp drive (registered)
//   led_right  out right lamp drive (registered)
//   click      out one-cycle pulse at the start of every on-phase
//   dbg_state  out current FSM state
// ----------------------------------------------------------------------------
module turn_signal_ctrl
   import car_sim_pkg::*;
#(
   parameter int CLK_HZ          = DEFAULT_CLK_HZ,
   parameter int BLINK_HZ        = 1,
   parameter int ESS_DIV         = 4,
   parameter int COMFORT_FLASHES = 3
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   sw_left,
   input  logic   sw_right,
   input  logic   sw_hazard,
   input  logic   ess_active,
   output logic   led_left,
   output logic   led_right,
   output logic   click,
   output state_t dbg_state
);

   localparam int P  = CLK_HZ / BLINK_HZ;
   localparam int PE = P / ESS_DIV;

   if ((P < 2) || ((P % 2) != 0) || (ESS_DIV < 1) || (PE < 2) ||
       ((PE % 2) != 0) || (COMFORT_FLASHES < 0)) begin : g_bad_params
      $error("turn_signal_ctrl: periods must be even and >= 2");
   end

   state_t r_state;
   state_t w_next_state;
   logic   w_restart;
   logic   w_comfort_entry;
   logic   w_on_phase;
   logic   w_phase_start;
   logic   r_led_left;
   logic   r_led_right;
   logic   r_click;

`ifdef TURN_SIGNAL_COMFORT_EN
   localparam int FW = (COMFORT_FLASHES > 0) ? $clog2(COMFORT_FLASHES + 1) : 1;
   localparam logic [FW-1:0] FLASH_MAX = FW'(COMFORT_FLASHES);

   logic [FW-1:0] r_flash;
   logic          w_on_last;
   logic          w_side_next;
`endif

   blink_timebase #(
      .P  (P),
      .PE (PE)
   ) u_timebase (
      .clk         (clk),
      .rst         (rst),
      .restart     (w_restart),
      .sel_ess     (w_next_state == ESS),
      .on_phase    (w_on_phase),
      .phase_start (w_phase_start)
`ifdef TURN_SIGNAL_COMFORT_EN
      ,
      .on_last     (w_on_last)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state    = IDLE;
      w_comfort_entry = 1'b0;
      if (ess_active) begin
         w_next_state = ESS;
      end else if (sw_hazard) begin
         w_next_state = HAZARD;
      end else if (sw_left && !sw_right) begin
         w_next_state = LEFT;
      end else if (sw_right && !sw_left) begin
         w_next_state = RIGHT;
      end else if (!sw_left && !sw_right) begin
`ifdef TURN_SIGNAL_COMFORT_EN
         // Comfort is only entered on release from a stalk state; hazard/ESS
         // release lands in IDLE, which discards any pending comfort.
         case (r_state)
            LEFT: begin
               if (r_flash < FLASH_MAX) begin
                  w_next_state    = COMFORT_L;
                  w_comfort_entry = 1'b1;
               end
            end
            RIGHT: begin
               if (r_flash < FLASH_MAX) begin
                  w_next_state    = COMFORT_R;
                  w_comfort_entry = 1'b1;
               end
            end
            COMFORT_L: begin
               if (!((r_flash == FLASH_MAX) && w_on_last)) begin
                  w_next_state = COMFORT_L;
               end
            end
            COMFORT_R: begin
               if (!((r_flash == FLASH_MAX) && w_on_last)) begin
                  w_next_state = COMFORT_R;
               end
            end
            default: begin
               w_next_state = IDLE;
            end
         endcase
`endif
      end
      // IDLE holds the counter at 0 so the next request starts a full phase.
      w_restart = ((w_next_state != r_state) && !w_comfort_entry) ||
                  (w_next_state == IDLE);
   end

`ifdef TURN_SIGNAL_COMFORT_EN
   assign w_side_next = (w_next_state inside {LEFT, RIGHT, COMFORT_L, COMFORT_R});

   // On-phases started since entering a stalk state; saturates at FLASH_MAX.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flash <= '0;
      end else if (w_restart) begin
         r_flash <= (w_next_state inside {LEFT, RIGHT}) ? FW'(1) : '0;
      end else if (w_phase_start && w_side_next && (r_flash < FLASH_MAX)) begin
         r_flash <= r_flash + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_led_left  <= 1'b0;
         r_led_right <= 1'b0;
         r_click     <= 1'b0;
      end else begin
         r_led_left  <= w_on_phase &&
                        (w_next_state inside {LEFT, COMFORT_L, HAZARD, ESS});
         r_led_right <= w_on_phase &&
                        (w_next_state inside {RIGHT, COMFORT_R, HAZARD, ESS});
         r_click     <= w_phase_start && (w_next_state != IDLE);
      end
   end

   assign led_left  = r_led_left;
   assign led_right = r_led_right;
   assign click     = r_click;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
`timescale 1ns/1ps
// Bench for turn_signal_ctrl with CLK_HZ=200, BLINK_HZ=10, ESS_DIV=5:
// P=20 (10 on / 10 off), PE=4 (2 on / 2 off). Expected lamp words are
// {led_left, led_right, click}, pushed by the driver and popped by the monitor.
module tb_turn_signal_ctrl;
  import car_sim_pkg::*;

  localparam int W = 3;
`ifdef TURN_SIGNAL_COMFORT_EN
  localparam bit COMFORT_ON = 1'b1;
`else
  localparam bit COMFORT_ON = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst;
  logic   sw_left;
  logic   sw_right;
  logic   sw_hazard;
  logic   ess_active;
  logic   led_left;
  logic   led_right;
  logic   click;
  state_t dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    rst        = 1'b1;
    sw_left    = 1'b0;
    sw_right   = 1'b0;
    sw_hazard  = 1'b0;
    ess_active = 1'b0;
  end

  turn_signal_ctrl #(
    .CLK_HZ          (200),
    .BLINK_HZ        (10),
    .ESS_DIV         (5),
    .COMFORT_FLASHES (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_left    (sw_left),
    .sw_right   (sw_right),
    .sw_hazard  (sw_hazard),
    .ess_active (ess_active),
    .led_left   (led_left),
    .led_right  (led_right),
    .click      (click),
    .dbg_state  (dbg_state)
  );

  // ---------------- driver ----------------
  // Inputs change on the falling edge; the expected word is the lamp state
  // visible just after the following rising edge.
  task automatic drive(input logic l, input logic r, input logic h,
                       input logic e, input logic rs,
                       input logic [W-1:0] exp, input string nm);
    @(negedge clk);
    sw_left    = l;
    sw_right   = r;
    sw_hazard  = h;
    ess_active = e;
    rst        = rs;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Lamp word for cycle c (1-based) of a flash that started at cycle 1.
  function automatic logic [W-1:0] blink(input int c, input int period,
                                         input logic on_l, input logic on_r);
    logic on;
    on = ((c - 1) % period) < (period / 2);
    return {on & on_l, on & on_r, ((c - 1) % period) == 0};
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        a = {led_left, led_right, click};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL %s: got l/r/click=%b required %b at %0t", nm, a, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 3'b000, "reset");
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 3'b000, "idle_after_reset");

    // Left stalk held 100 cycles: on 1-10, 21-30, ...; clicks at 1, 21, ...
    for (int c = 1; c <= 100; c++) drive(1, 0, 0, 0, 0, blink(c, 20, 1, 0), "left_held");
    // Five on-phases already seen, so release goes straight to IDLE.
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 3'b000, "left_release");

    // Short tap: comfort gives 3 full on-phases (1-10, 21-30, 41-50).
    for (int c = 1; c <= 3; c++) drive(1, 0, 0, 0, 0, blink(c, 20, 1, 0), "left_tap");
    for (int c = 4; c <= 60; c++)
      drive(0, 0, 0, 0, 0, (COMFORT_ON && c <= 50) ? blink(c, 20, 1, 0) : 3'b000,
            "comfort_left");

    // ESS over LEFT: fast 2/2 both lamps, then LEFT restarts a full phase.
    for (int c = 1; c <= 5; c++)  drive(1, 0, 0, 0, 0, blink(c, 20, 1, 0), "left_pre_ess");
    for (int c = 1; c <= 12; c++) drive(1, 0, 0, 1, 0, blink(c, 4, 1, 1), "ess");
    for (int c = 1; c <= 25; c++) drive(1, 0, 0, 0, 0, blink(c, 20, 1, 0), "left_after_ess");

    // Both stalks: treated as no input, no comfort, no click.
    for (int i = 0; i < 50; i++) drive(1, 1, 0, 0, 0, 3'b000, "both_stalks");
    for (int i = 0; i < 3; i++)  drive(0, 0, 0, 0, 0, 3'b000, "both_release");

    // Hazard: both lamps at the normal rate; release goes to IDLE.
    for (int c = 1; c <= 25; c++) drive(0, 0, 1, 0, 0, blink(c, 20, 1, 1), "hazard");
    for (int i = 0; i < 3; i++)   drive(0, 0, 0, 0, 0, 3'b000, "hazard_release");

    // Opposite stalk during comfort: fresh right-side phase.
    for (int c = 1; c <= 3; c++) drive(1, 0, 0, 0, 0, blink(c, 20, 1, 0), "left_tap2");
    for (int c = 4; c <= 8; c++)
      drive(0, 0, 0, 0, 0, COMFORT_ON ? blink(c, 20, 1, 0) : 3'b000, "comfort_left2");
    for (int c = 1; c <= 15; c++) drive(0, 1, 0, 0, 0, blink(c, 20, 0, 1), "right_over_comfort");
    for (int i = 0; i < 2; i++)   drive(1, 1, 0, 0, 0, 3'b000, "cancel_both");

    // Reset during COMFORT_R: everything dark at once and afterwards.
    for (int c = 1; c <= 2; c++) drive(0, 1, 0, 0, 0, blink(c, 20, 0, 1), "right_tap");
    for (int c = 3; c <= 7; c++)
      drive(0, 0, 0, 0, 0, COMFORT_ON ? blink(c, 20, 0, 1) : 3'b000, "comfort_right");
    drive(0, 0, 0, 0, 1, 3'b000, "reset_in_comfort");
    for (int i = 0; i < 40; i++) drive(0, 0, 0, 0, 0, 3'b000, "after_reset");

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/turn_signal_ctrl.md
TURN_SIGNAL_CTRL -- requirements
Module: turn_signal_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BLINK_HZ, default 1, normal flash rate in Hz; period P = CLK_HZ/BLINK_HZ cycles.
REQ-003 SHALL have parameter ESS_DIV, default 4, ESS flash-rate multiplier; ESS period PE = P/ESS_DIV.
REQ-004 SHALL have parameter COMFORT_FLASHES, default 3, minimum on-phases after a short stalk tap.
REQ-005 clk  input  1  system clock; one clock domain only.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 sw_left  input  1  left stalk level; synchronous to clk, synchronised upstream.
REQ-008 sw_right  input  1  right stalk level; synchronous to clk.
REQ-009 sw_hazard  input  1  hazard switch level.
REQ-010 ess_active  input  1  emergency-stop-signal request from braking logic.
REQ-011 led_left  output  1  left lamp drive, registered.
REQ-012 led_right  output  1  right lamp drive, registered.
REQ-013 click  output  1  one-cycle pulse at start of every on-phase, for the relay-click sound.

Function
REQ-014 FSM states: IDLE, LEFT, RIGHT, HAZARD, ESS, COMFORT_L, COMFORT_R.
REQ-015 Priority, evaluated every cycle: ess_active > sw_hazard > single stalk > comfort > IDLE.
REQ-016 sw_left and sw_right both high, with no hazard/ESS: treated as no stalk input; comfort cancelled; next state IDLE.
REQ-017 Phase counter counts 0..P-1 (ESS: 0..PE-1), wraps to 0; on-phase is count < period/2, i.e. 50% duty.
REQ-018 Counter width $clog2(P); counter and flash counter SHALL NOT overflow at any legal parameter set.
REQ-019 Any state change restarts the counter at 0 so the first on-phase is full length; no restart on COMFORT entry from same-side state.
REQ-020 Latency: input change to LED change is exactly 1 cycle (registered outputs).
REQ-021 LEFT/COMFORT_L drive led_left only; RIGHT/COMFORT_R drive led_right only; HAZARD and ESS drive both in phase; IDLE drives both 0.
REQ-022 click pulses on the cycle an on-phase starts in any non-IDLE state; never in IDLE.
REQ-023 Flash counter counts on-phases started since entering LEFT/RIGHT, saturating at COMFORT_FLASHES.
REQ-024 Stalk release while flash count < COMFORT_FLASHES: enter COMFORT_x; stay until COMFORT_FLASHES on-phases completed, then IDLE at end of that on-phase.
REQ-025 Opposite stalk during COMFORT_x: cancel, enter other side with fresh phase and flash count.
REQ-026 Hazard/ESS during COMFORT_x: comfort discarded; on their release return to IDLE or current stalk state.
REQ-027 Illegal parameters (P odd, P < 2, PE odd or < 2) SHALL stop elaboration with an error.

Reset
REQ-028 On rst high at a clk edge: state IDLE, counters 0, led_left=0, led_right=0, click=0.
REQ-029 Reset mid-operation (any state, incl. COMFORT) SHALL abort with no residual flash after release.
REQ-030 First cycle after reset release evaluates inputs normally; active request starts a full on-phase.

Configuration
REQ-031 Macro TURN_SIGNAL_COMFORT_EN: when defined, REQ-023..REQ-026 apply.
REQ-032 When undefined: no COMFORT states or flash counter; stalk release goes to IDLE next cycle, LED 0.

Structure
REQ-033 Shared package car_sim_pkg SHALL hold the state enum type and the default CLK_HZ constant.
REQ-034 Sub-module blink_timebase (period-selectable phase counter, restart input, on_phase and phase_start outputs) is instantiated once.

Verification (CLK_HZ=100, BLINK_HZ=10 -> P=10, PE=ESS_DIV 2 -> 5 invalid; use ESS_DIV=1 with PE=10 or CLK_HZ=200 -> P=20, PE=4 ... bench uses CLK_HZ=200, BLINK_HZ=10, ESS_DIV=5: P=20, PE=4)
REQ-035 sw_left held 100 cycles -> led_left high cycles 1-10, 21-30, ..., low otherwise; led_right 0; click at 1, 21, 41, 61, 81.
REQ-036 sw_left tapped 3 cycles (macro on) -> exactly 3 on-phases of 10 cycles each, then IDLE; macro off -> one 3-cycle pulse only.
REQ-037 ess_active raised during LEFT -> next cycle both LEDs follow 4-cycle period, 2 on/2 off; drop ess -> LEFT restarts full phase.
REQ-038 sw_left and sw_right both high 50 cycles -> both LEDs 0, click never pulses.
REQ-039 rst asserted at cycle 5 of COMFORT_R -> next cycle all outputs 0; no flash after rst release with inputs low.
